// File: rtl/dmem_mmio_if.sv
// Data-port bundle between the mips core (master) and the dmem_mmio responder (slave),
// plus the LED, timer and TX byte stream outputs of the I/O page.
interface dmem_mmio_if;
   logic        memwrite;
   logic [31:0] addr;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [15:0] leds;
   logic        timer_match;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   modport master (
      output memwrite, addr, writedata, tx_ready,
      input  readdata, leds, timer_match, tx_data, tx_valid
   );

   modport slave (
      input  memwrite, addr, writedata, tx_ready,
      output readdata, leds, timer_match, tx_data, tx_valid
   );
endinterface

// File: rtl/dmem_mmio.sv
// Data-side memory responder: 32-bit word RAM plus an I/O page with LEDs,
// a free-running timer with sticky compare match, and a byte TX FIFO.
module dmem_mmio #(
   parameter int RAM_WORDS  = 64,
   parameter int FIFO_DEPTH = 8
) (
   input  logic       clk,
   input  logic       reset,
   dmem_mmio_if.slave bus
);
   localparam int RAM_AW = $clog2(RAM_WORDS);
   localparam int PW     = $clog2(FIFO_DEPTH);
   localparam int CW     = PW + 1;

   localparam logic [29:0] W_LED      = 30'h200;
   localparam logic [29:0] W_TCOUNT   = 30'h201;
   localparam logic [29:0] W_TCOMPARE = 30'h202;
   localparam logic [29:0] W_STATUS   = 30'h203;
   localparam logic [29:0] W_TXDATA   = 30'h204;
   localparam logic [29:0] W_TXSTAT   = 30'h205;

   // ------------------------------------------------------------------
   // Address decode (byte offset bits are ignored)
   // ------------------------------------------------------------------
   logic [29:0]       word;
   logic [RAM_AW-1:0] ram_idx;
   logic              sel_ram;
   logic              wr_ram, wr_led, wr_tcount, wr_tcompare, wr_status, wr_txdata;
   logic              unused_bits;

   assign word        = bus.addr[31:2];
   assign ram_idx     = bus.addr[RAM_AW+1:2];
   assign sel_ram     = (bus.addr[31:RAM_AW+2] == '0);
   assign unused_bits = ^bus.addr[1:0];

   assign wr_ram      = bus.memwrite && sel_ram;
   assign wr_led      = bus.memwrite && (word == W_LED);
   assign wr_tcount   = bus.memwrite && (word == W_TCOUNT);
   assign wr_tcompare = bus.memwrite && (word == W_TCOMPARE);
   assign wr_status   = bus.memwrite && (word == W_STATUS);
   assign wr_txdata   = bus.memwrite && (word == W_TXDATA);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [15:0]   led_reg,      led_next;
   logic [31:0]   tcount_reg,   tcount_next;
   logic [31:0]   tcompare_reg, tcompare_next;
   logic          match_reg,    match_next;
   logic          overflow_reg, overflow_next;
   logic [PW-1:0] rd_ptr_reg,   rd_ptr_next;
   logic [PW-1:0] wr_ptr_reg,   wr_ptr_next;
   logic [CW-1:0] count_reg,    count_next;

   logic fifo_full, fifo_empty;
   logic pop, push, drop;

   assign fifo_full  = (count_reg == CW'(FIFO_DEPTH));
   assign fifo_empty = (count_reg == '0);
   assign pop        = !fifo_empty && bus.tx_ready;
   // A full FIFO still takes a push when the head leaves on the same edge.
   assign push       = wr_txdata && (!fifo_full || pop);
   assign drop       = wr_txdata && fifo_full && !pop;

   // ------------------------------------------------------------------
   // RAM: contents survive reset; reset only blocks the write
   // ------------------------------------------------------------------
   logic [31:0] ram [RAM_WORDS];

   always_ff @(posedge clk) begin
      if (reset && wr_ram)
         ram[ram_idx] <= bus.writedata;
   end

   // ------------------------------------------------------------------
   // TX FIFO storage, one byte register per slot
   // ------------------------------------------------------------------
   logic [7:0] entry_data [FIFO_DEPTH];

   genvar gi;
   generate
      for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
         logic [7:0] entry_reg;
         always_ff @(posedge clk) begin
            if (push && (wr_ptr_reg == PW'(gi)))
               entry_reg <= bus.writedata[7:0];
         end
         assign entry_data[gi] = entry_reg;
      end
   endgenerate

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      led_next      = led_reg;
      tcount_next   = tcount_reg + 32'd1;
      tcompare_next = tcompare_reg;
      match_next    = match_reg;
      overflow_next = overflow_reg;
      rd_ptr_next   = rd_ptr_reg;
      wr_ptr_next   = wr_ptr_reg;
      count_next    = count_reg;

      if (wr_led)
         led_next = bus.writedata[15:0];
      if (wr_tcount)
         tcount_next = bus.writedata;
      if (wr_tcompare)
         tcompare_next = bus.writedata;

      if (wr_status && bus.writedata[0])
         match_next = 1'b0;
      // Ordered after the clear so a simultaneous match wins.
      if (tcount_reg == tcompare_reg)
         match_next = 1'b1;

      if (wr_status && bus.writedata[1])
         overflow_next = 1'b0;
      if (drop)
         overflow_next = 1'b1;

      if (pop)
         rd_ptr_next = rd_ptr_reg + PW'(1);
      if (push)
         wr_ptr_next = wr_ptr_reg + PW'(1);

      unique case ({push, pop})
         2'b10:   count_next = count_reg + CW'(1);
         2'b01:   count_next = count_reg - CW'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         led_reg      <= '0;
         tcount_reg   <= '0;
         tcompare_reg <= '1;
         match_reg    <= 1'b0;
         overflow_reg <= 1'b0;
         rd_ptr_reg   <= '0;
         wr_ptr_reg   <= '0;
         count_reg    <= '0;
      end else begin
         led_reg      <= led_next;
         tcount_reg   <= tcount_next;
         tcompare_reg <= tcompare_next;
         match_reg    <= match_next;
         overflow_reg <= overflow_next;
         rd_ptr_reg   <= rd_ptr_next;
         wr_ptr_reg   <= wr_ptr_next;
         count_reg    <= count_next;
      end
   end

   // ------------------------------------------------------------------
   // Read mux (zero latency) and outputs
   // ------------------------------------------------------------------
   logic [31:0] rdata;

   always_comb begin
      rdata = '0;
      if (sel_ram) begin
         rdata = ram[ram_idx];
      end else begin
         case (word)
            W_LED:      rdata = {16'h0, led_reg};
            W_TCOUNT:   rdata = tcount_reg;
            W_TCOMPARE: rdata = tcompare_reg;
            W_STATUS:   rdata = {30'h0, overflow_reg, match_reg};
            W_TXSTAT:   rdata = {26'h0, fifo_full, fifo_empty, 4'(count_reg)};
            default:    rdata = '0;
         endcase
      end
   end

   assign bus.readdata    = rdata;
   assign bus.leds        = led_reg;
   assign bus.timer_match = match_reg;
   assign bus.tx_valid    = !fifo_empty;
   assign bus.tx_data     = entry_data[rd_ptr_reg];
endmodule

// File: tb/tb_dmem_mmio.sv
// Bench for dmem_mmio: directed scenarios plus random traffic, all checked
// against a queue/array reference model of the memory map.
module tb_dmem_mmio;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic reset;

   dmem_mmio_if bus ();

   dmem_mmio #(.RAM_WORDS(64), .FIFO_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int n_txn    = 0;

   // Reference model state
   logic [31:0] m_ram    [64];
   bit          m_ram_ok [64];
   logic [15:0] m_leds;
   logic [31:0] m_tcount;
   logic [31:0] m_tcompare;
   bit          m_match;
   bit          m_ovf;
   logic [7:0]  m_q [$];

   logic [31:0] rd;
   logic [31:0] r_a, r_d;
   bit          r_we, r_rdy;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   function automatic bit model_read(input logic [31:0] a, output logic [31:0] v);
      logic [31:0] wa;
      wa = {a[31:2], 2'b00};
      v  = 32'h0;
      if (a < 32'h100) begin
         if (!m_ram_ok[a[7:2]])
            return 1'b0;
         v = m_ram[a[7:2]];
         return 1'b1;
      end
      case (wa)
         32'h800: v = {16'h0, m_leds};
         32'h804: v = m_tcount;
         32'h808: v = m_tcompare;
         32'h80C: v = {30'h0, m_ovf, m_match};
         32'h814: v = 32'(m_q.size()) | ((m_q.size() == 0) ? 32'h10 : 32'h0)
                     | ((m_q.size() == DEPTH) ? 32'h20 : 32'h0);
         default: v = 32'h0;
      endcase
      return 1'b1;
   endfunction

   // One clock edge of the memory map, evaluated from the pre-edge state.
   task automatic model_step(input bit we, input logic [31:0] a, input logic [31:0] d, input bit rdy);
      bit          hit;
      logic [31:0] nxt;
      logic [31:0] wa;
      hit = (m_tcount == m_tcompare);
      nxt = m_tcount + 32'd1;
      wa  = {a[31:2], 2'b00};
      if (rdy && m_q.size() != 0)
         void'(m_q.pop_front());
      if (we) begin
         if (a < 32'h100) begin
            m_ram[a[7:2]]    = d;
            m_ram_ok[a[7:2]] = 1'b1;
         end else begin
            case (wa)
               32'h800: m_leds = d[15:0];
               32'h804: nxt = d;
               32'h808: m_tcompare = d;
               32'h80C: begin
                  if (d[0]) m_match = 1'b0;
                  if (d[1]) m_ovf = 1'b0;
               end
               32'h810: begin
                  if (m_q.size() < DEPTH) m_q.push_back(d[7:0]);
                  else m_ovf = 1'b1;
               end
               default: ;
            endcase
         end
      end
      if (hit)
         m_match = 1'b1;
      m_tcount = nxt;
   endtask

   task automatic step(input bit we, input logic [31:0] a, input logic [31:0] d, input bit rdy,
                       output logic [31:0] rdo);
      logic [31:0] exp;
      bit          known;
      bus.memwrite  = we;
      bus.addr      = a;
      bus.writedata = d;
      bus.tx_ready  = rdy;
      #1;
      rdo   = bus.readdata;
      known = model_read(a, exp);
      if (known)
         check("readdata", rdo, exp);
      check("leds", {16'h0, bus.leds}, {16'h0, m_leds});
      check("timer_match", 32'(bus.timer_match), 32'(m_match));
      check("tx_valid", 32'(bus.tx_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0)
         check("tx_data", 32'(bus.tx_data), 32'(m_q[0]));
      $display("txn %0d we=%0d addr=%h wd=%h rdy=%0d rd=%h", n_txn, we, a, d, rdy, rdo);
      n_txn++;
      model_step(we, a, d, rdy);
      @(posedge clk);
      #1;
   endtask

   // One-cycle reset with a competing LED write that must lose.
   task automatic do_reset();
      reset         = 1'b0;
      bus.memwrite  = 1'b1;
      bus.addr      = 32'h800;
      bus.writedata = 32'hFFFF_FFFF;
      bus.tx_ready  = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      reset        = 1'b1;
      bus.memwrite = 1'b0;
      m_leds     = '0;
      m_tcount   = '0;
      m_tcompare = '1;
      m_match    = 1'b0;
      m_ovf      = 1'b0;
      m_q.delete();
      $display("txn %0d reset", n_txn);
      n_txn++;
   endtask

   initial begin
      #300000;
      $display("FAIL timeout: simulation exceeded its time budget");
      $fatal(1, "timeout");
   end

   initial begin
      reset         = 1'b1;
      bus.memwrite  = 1'b0;
      bus.addr      = '0;
      bus.writedata = '0;
      bus.tx_ready  = 1'b0;
      for (int i = 0; i < 64; i++) m_ram_ok[i] = 1'b0;

      // Reset state
      do_reset();
      check("rst_leds", {16'h0, bus.leds}, 32'h0);
      check("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
      check("rst_match", 32'(bus.timer_match), 32'h0);
      step(0, 32'h804, 0, 0, rd);  check("rst_tcount", rd, 32'h0);
      step(0, 32'h804, 0, 0, rd);  check("tcount_after_release", rd, 32'h1);
      step(0, 32'h808, 0, 0, rd);  check("rst_tcompare", rd, 32'hFFFF_FFFF);
      step(0, 32'h814, 0, 0, rd);  check("rst_txstat", rd, 32'h10);

      // RAM, unmapped, LED
      step(1, 32'h04, 32'hDEAD_BEEF, 0, rd);
      step(0, 32'h04, 0, 0, rd);   check("ram_04", rd, 32'hDEAD_BEEF);
      step(0, 32'h900, 0, 0, rd);  check("unmapped_900", rd, 32'h0);
      step(1, 32'h800, 32'h1234_ABCD, 0, rd);
      check("leds_abcd", {16'h0, bus.leds}, 32'h0000_ABCD);
      step(0, 32'h802, 0, 0, rd);  check("led_read", rd, 32'h0000_ABCD);

      // Timer compare match
      step(1, 32'h80C, 3, 0, rd);
      step(1, 32'h808, 10, 0, rd);
      step(1, 32'h804, 0, 0, rd);
      for (int i = 1; i <= 10; i++) begin
         step(0, 32'h900, 0, 0, rd);
         check("match_early", 32'(bus.timer_match), 32'h0);
      end
      step(0, 32'h900, 0, 0, rd);
      check("match_at_11", 32'(bus.timer_match), 32'h1);
      step(1, 32'h80C, 1, 0, rd);
      check("match_cleared", 32'(bus.timer_match), 32'h0);
      step(1, 32'h804, 5, 0, rd);
      for (int i = 0; i < 5; i++) step(0, 32'h900, 0, 0, rd);
      step(1, 32'h80C, 1, 0, rd);
      check("match_set_wins", 32'(bus.timer_match), 32'h1);

      // Timer wrap
      step(1, 32'h804, 32'hFFFF_FFFE, 0, rd);
      step(0, 32'h900, 0, 0, rd);
      step(0, 32'h900, 0, 0, rd);
      step(0, 32'h804, 0, 0, rd);  check("tcount_wrap", rd, 32'h0);
      step(1, 32'h80C, 3, 0, rd);

      // FIFO fill, overflow, drain
      for (int i = 0; i < 8; i++) step(1, 32'h810, 32'h41 + i, 0, rd);
      step(0, 32'h814, 0, 0, rd);  check("txstat_full", rd, 32'h28);
      step(1, 32'h810, 32'h49, 0, rd);
      step(0, 32'h814, 0, 0, rd);  check("txstat_after_drop", rd, 32'h28);
      step(0, 32'h80C, 0, 0, rd);  check("overflow_set", 32'(rd[1]), 32'h1);
      for (int i = 0; i < 8; i++) begin
         check("drain_valid", 32'(bus.tx_valid), 32'h1);
         check("drain_byte", 32'(bus.tx_data), 32'h41 + i);
         step(0, 32'h900, 0, 1, rd);
      end
      check("drained_valid", 32'(bus.tx_valid), 32'h0);
      step(0, 32'h814, 0, 1, rd);  check("txstat_empty", rd, 32'h10);
      step(1, 32'h80C, 2, 0, rd);

      // Push into a full FIFO while it pops
      for (int i = 0; i < 8; i++) step(1, 32'h810, 32'h60 + i, 0, rd);
      step(1, 32'h810, 32'h55, 1, rd);
      step(0, 32'h814, 0, 0, rd);  check("txstat_push_on_pop", rd, 32'h28);
      step(0, 32'h80C, 0, 0, rd);  check("no_overflow", 32'(rd[1]), 32'h0);
      for (int i = 0; i < 8; i++) begin
         check("push_on_pop_order", 32'(bus.tx_data), (i == 7) ? 32'h55 : 32'h61 + i);
         step(0, 32'h900, 0, 1, rd);
      end

      // Reset mid-transfer
      for (int i = 0; i < 3; i++) step(1, 32'h810, 32'h70 + i, 0, rd);
      do_reset();
      check("mid_rst_tx_valid", 32'(bus.tx_valid), 32'h0);
      check("mid_rst_leds", {16'h0, bus.leds}, 32'h0);
      step(0, 32'h814, 0, 0, rd);  check("mid_rst_txstat", rd, 32'h10);
      step(0, 32'h808, 0, 0, rd);  check("mid_rst_tcompare", rd, 32'hFFFF_FFFF);
      step(0, 32'h04, 0, 0, rd);   check("ram_survives_reset", rd, 32'hDEAD_BEEF);

      // Random traffic against the model
      for (int k = 0; k < 1200; k++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
         end else begin
            case ($urandom_range(0, 5))
               0, 1:    r_a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
               2, 3:    r_a = 32'h800 + 32'($urandom_range(0, 5)) * 4 + 32'($urandom_range(0, 3));
               4:       r_a = 32'h818 + 32'($urandom_range(0, 255)) * 4;
               default: r_a = $urandom;
            endcase
            r_d   = ($urandom_range(0, 3) == 0) ? m_tcount + 32'($urandom_range(0, 8)) : $urandom;
            r_we  = ($urandom_range(0, 2) != 0);
            r_rdy = ($urandom_range(0, 2) == 0);
            step(r_we, r_a, r_d, r_rdy, rd);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
